// File: rtl/hydra_pkg.sv
// hydra_pkg: shared widths, read-engine state and packet descriptor types
package hydra_pkg;
  localparam int PRIO_NUM    = 8;
  localparam int SRAM_IDX_W  = 5;
  localparam int SRAM_ADDR_W = 11;
  localparam int PKT_LEN_W   = 9;
  localparam int PRIO_W      = $clog2(PRIO_NUM);
  localparam int CRED_W      = $clog2(PRIO_NUM) + 1;
  localparam int DATA_W      = 16;
  typedef enum logic [1:0] {IDLE, POP, ISSUE, DRAIN} rd_state_t;
  typedef struct packed {
    logic [SRAM_IDX_W-1:0]  sram;
    logic [SRAM_ADDR_W-1:0] head;
    logic [PKT_LEN_W-1:0]   length;
  } rd_desc_t;
  // packets per round granted to queue q
  function automatic logic [CRED_W-1:0] weight(input logic [PRIO_W-1:0] q);
    return CRED_W'(q) + CRED_W'(1);
  endfunction
endpackage

// File: rtl/port_rd_backend_if.sv
// port_rd_backend_if: queue status, descriptor pop, SRAM read and egress stream of one port
interface port_rd_backend_if;
  import hydra_pkg::*;
  logic                   ready;
  logic                   wrr_enable;
  logic [PRIO_NUM-1:0]    queue_nonempty;
  logic                   pop_req;
  logic [PRIO_W-1:0]      pop_prior;
  logic                   pop_ack;
  logic [SRAM_IDX_W-1:0]  pkt_sram;
  logic [SRAM_ADDR_W-1:0] pkt_head;
  logic [PKT_LEN_W-1:0]   pkt_length;
  logic                   sram_rd_en;
  logic [SRAM_IDX_W-1:0]  sram_rd_sram;
  logic [SRAM_ADDR_W-1:0] sram_rd_addr;
  logic                   sram_rd_gnt;
  logic [DATA_W-1:0]      sram_rd_data;
  logic                   rd_sop;
  logic                   rd_eop;
  logic                   rd_vld;
  logic [DATA_W-1:0]      rd_data;
  modport master (
    input  ready, wrr_enable, queue_nonempty, pop_ack, pkt_sram, pkt_head, pkt_length,
           sram_rd_gnt, sram_rd_data,
    output pop_req, pop_prior, sram_rd_en, sram_rd_sram, sram_rd_addr,
           rd_sop, rd_eop, rd_vld, rd_data
  );
  modport slave (
    output ready, wrr_enable, queue_nonempty, pop_ack, pkt_sram, pkt_head, pkt_length,
           sram_rd_gnt, sram_rd_data,
    input  pop_req, pop_prior, sram_rd_en, sram_rd_sram, sram_rd_addr,
           rd_sop, rd_eop, rd_vld, rd_data
  );
endinterface

// File: rtl/port_rd_backend_scheduler.sv
// port_rd_scheduler: queue selection, strict priority or WRR (WRR compiled in with PORT_RD_WRR_EN)
module port_rd_scheduler
  import hydra_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                wrr_enable_i,
  input  logic [PRIO_NUM-1:0] queue_nonempty_i,
  input  logic                take_i,
  input  logic                done_i,
  output logic [PRIO_W-1:0]   sel_o
);
  logic [PRIO_W-1:0] strict_sel;
  // highest-index nonempty queue wins
  always_comb begin
    strict_sel = '0;
    for (int i = 0; i < PRIO_NUM; i++) strict_sel = queue_nonempty_i[i] ? PRIO_W'(i) : strict_sel;
  end
`ifdef PORT_RD_WRR_EN
  logic [PRIO_W-1:0] ptr_q, ptr_d, wrr_sel, ptr_m1;
  logic [CRED_W-1:0] cred_q, cred_d;
  logic              wrr_q, wrr_d;
  // first nonempty queue searching downward from ptr, wrapping 0 -> top
  always_comb begin
    wrr_sel = ptr_q;
    for (int i = PRIO_NUM - 1; i >= 0; i--)
      wrr_sel = queue_nonempty_i[ptr_q - PRIO_W'(i)] ? ptr_q - PRIO_W'(i) : wrr_sel;
  end
  assign sel_o  = wrr_enable_i ? wrr_sel : strict_sel;
  assign ptr_m1 = ptr_q - PRIO_W'(1);
  // jump to a skipped-to queue on launch; spend one credit per finished packet
  always_comb begin
    wrr_d  = take_i ? wrr_enable_i : wrr_q;
    ptr_d  = ptr_q;
    cred_d = cred_q;
    if (take_i && wrr_enable_i && wrr_sel != ptr_q) begin
      ptr_d  = wrr_sel;
      cred_d = weight(wrr_sel);
    end
    if (done_i && wrr_q) begin
      ptr_d  = cred_q == CRED_W'(1) ? ptr_m1 : ptr_q;
      cred_d = cred_q == CRED_W'(1) ? weight(ptr_m1) : cred_q - CRED_W'(1);
    end
  end
  // WRR pointer, credit and the mode the current packet was launched under
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q  <= PRIO_W'(PRIO_NUM - 1);
      cred_q <= CRED_W'(PRIO_NUM);
      wrr_q  <= 1'b0;
    end else begin
      ptr_q  <= ptr_d;
      cred_q <= cred_d;
      wrr_q  <= wrr_d;
    end
  end
`else
  logic unused_wrr;
  assign sel_o      = strict_sel;
  assign unused_wrr = &{1'b0, clk, rst, wrr_enable_i, take_i, done_i};
`endif
endmodule

// File: rtl/port_rd_backend.sv
// port_rd_backend: per-port transmit engine (pop descriptor, fetch words, stream out); WRR via PORT_RD_WRR_EN
module port_rd_backend
  import hydra_pkg::*;
#(
  parameter int SRAM_RD_LATENCY = 2
) (
  input  logic                clk,
  input  logic                rst,
  port_rd_backend_if.master   bus
);
  localparam int L = SRAM_RD_LATENCY;
  rd_state_t          state_q, state_d;
  rd_desc_t           desc_q, desc_d;
  logic [PKT_LEN_W-1:0] iss_q, iss_d;
  logic [PKT_LEN_W:0]   rx_q, rx_d;
  logic [L-1:0]         sr_q, sr_d;
  logic [L:0]           sr_ext;
  logic [PRIO_W-1:0]    prior_q, prior_d;
  logic                 sop_q, sop_d, eop_q, eop_d, vld_q, vld_d;
  logic [DATA_W-1:0]    data_q, data_d;
  logic [PRIO_W-1:0]    sel;
  logic                 take, acc, fire, last, done, arrive;

  port_rd_scheduler u_sched (
    .clk              (clk),
    .rst              (rst),
    .wrr_enable_i     (bus.wrr_enable),
    .queue_nonempty_i (bus.queue_nonempty),
    .take_i           (take),
    .done_i           (done),
    .sel_o            (sel)
  );

  assign take   = state_q == IDLE && bus.ready && |bus.queue_nonempty;
  assign acc    = state_q == POP && bus.pop_ack;
  assign fire   = state_q == ISSUE && bus.sram_rd_gnt;
  assign last   = iss_q == desc_q.length;
  assign done   = state_q == DRAIN && rx_q == {1'b0, desc_q.length} + (PKT_LEN_W+1)'(1);
  assign arrive = sr_q[L-1];

  assign bus.pop_req      = state_q == POP;
  assign bus.pop_prior    = prior_q;
  assign bus.sram_rd_en   = state_q == ISSUE;
  assign bus.sram_rd_sram = desc_q.sram;
  assign bus.sram_rd_addr = desc_q.head + SRAM_ADDR_W'(iss_q);
  assign bus.rd_sop       = sop_q;
  assign bus.rd_eop       = eop_q;
  assign bus.rd_vld       = vld_q;
  assign bus.rd_data      = data_q;

  // next state, descriptor latch, issue/receive counters and read-latency tracker
  always_comb begin
    state_d = take ? POP : acc ? ISSUE : (fire && last) ? DRAIN : done ? IDLE : state_q;
    desc_d  = acc ? '{sram: bus.pkt_sram, head: bus.pkt_head, length: bus.pkt_length} : desc_q;
    prior_d = take ? sel : prior_q;
    iss_d   = acc ? '0 : fire ? iss_q + PKT_LEN_W'(1) : iss_q;
    rx_d    = acc ? '0 : arrive ? rx_q + (PKT_LEN_W+1)'(1) : rx_q;
    sr_ext  = {sr_q, fire};
    sr_d    = sr_ext[L-1:0];
    sop_d   = acc;
    eop_d   = done;
    vld_d   = arrive;
    data_d  = arrive ? bus.sram_rd_data : data_q;
  end

  // state and datapath registers; reset drops everything in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      desc_q  <= '0;
      prior_q <= '0;
      iss_q   <= '0;
      rx_q    <= '0;
      sr_q    <= '0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      vld_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      desc_q  <= desc_d;
      prior_q <= prior_d;
      iss_q   <= iss_d;
      rx_q    <= rx_d;
      sr_q    <= sr_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
      vld_q   <= vld_d;
      data_q  <= data_d;
    end
  end
endmodule

// File: tb/tb_port_rd_backend.sv
// tb_port_rd_backend: randomized packet traffic against a queue-based reference of the port read engine
module tb_port_rd_backend;
  localparam int L = 2;
  logic clk, rst;
  int   total, bad, cyc;
  logic [15:0] pipe [L];

  port_rd_backend_if bus ();
  port_rd_backend #(.SRAM_RD_LATENCY(L)) dut (.clk(clk), .rst(rst), .bus(bus));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  function automatic logic [15:0] mem(input logic [4:0] s, input logic [10:0] a);
    return {s, a} ^ 16'ha5c3;
  endfunction

  function automatic logic [2:0] hi(input logic [7:0] q);
    hi = 3'd0;
    for (int i = 0; i < 8; i++) if (q[i]) hi = 3'(i);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    pipe[0] <= (bus.sram_rd_en && bus.sram_rd_gnt) ? mem(bus.sram_rd_sram, bus.sram_rd_addr) : 16'hdead;
    for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
  end
  assign bus.sram_rd_data = pipe[L-1];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run_pkt(input logic [2:0] ep, input logic [4:0] s, input logic [10:0] h,
                         input logic [8:0] n, input int ack_dly, input int stall_at,
                         input int stall_len, input bit rnd, input bit drop);
    int t, k, got, ns, first_g, last_g, first_v, last_v, ack_cyc;
    bit seen, g;
    logic [15:0] exp_q[$];
    logic [10:0] ea;
    t = 0;
    while (!bus.pop_req && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("pop_wait", bus.pop_req, 1);
    if (!bus.pop_req) return;
    chk("pop_prior", bus.pop_prior, ep);
    for (int i = 0; i < ack_dly; i++) begin
      @(negedge clk);
      chk("pop_hold", {bus.pop_req, bus.pop_prior}, {1'b1, ep});
    end
    chk("en_pre", bus.sram_rd_en, 0);
    bus.pop_ack = 1'b1; bus.pkt_sram = s; bus.pkt_head = h; bus.pkt_length = n;
    ack_cyc = cyc;
    for (int i = 0; i <= int'(n); i++) exp_q.push_back(mem(s, h + 11'(i)));
    @(negedge clk);
    bus.pop_ack = 1'b0;
    if (drop) bus.ready = 1'b0;
    k = 0; got = 0; ns = 0; seen = 0;
    first_g = -1; last_g = -1; first_v = -1; last_v = -1;
    t = 0;
    while (t < 3000) begin
      if (t == 0) begin
        chk("sop", bus.rd_sop, 1);
        chk("en_first", bus.sram_rd_en, 1);
      end
      if (t == 1) chk("sop_pulse", bus.rd_sop, 0);
      if (bus.rd_vld) begin
        if (got == 0) begin
          chk("vld_lat", cyc - first_g, L + 1);
          first_v = cyc;
        end
        if (exp_q.size() > 0) chk("data", bus.rd_data, exp_q.pop_front());
        else chk("extra_vld", got, int'(n));
        got++;
        last_v = cyc;
      end
      if (bus.rd_eop) begin
        chk("eop_lat", cyc - last_v, 1);
        chk("pop_after_eop", bus.pop_req, 0);
        seen = 1;
        break;
      end
      if (bus.sram_rd_en && k <= int'(n)) begin
        ea = h + 11'(k);
        chk("addr", bus.sram_rd_addr, ea);
        g = rnd ? ($urandom_range(0, 3) != 0) : !(k >= stall_at && ns < stall_len);
        if (!g && k > 0) ns++;
        if (g) begin
          if (k == 0) first_g = cyc;
          last_g = cyc;
          k++;
        end
        bus.sram_rd_gnt = g;
      end else begin
        if (bus.sram_rd_en) chk("over_issue", k, int'(n));
        bus.sram_rd_gnt = rnd ? 1'($urandom) : 1'b0;
      end
      @(negedge clk);
      t++;
    end
    bus.sram_rd_gnt = 1'b0;
    chk("eop_seen", seen, 1);
    chk("issued", k, int'(n) + 1);
    chk("rcvd", got, int'(n) + 1);
    chk("span", last_v - first_v, rnd ? last_g - first_g : int'(n) + stall_len);
    if (!rnd) chk("first_gnt", first_g - ack_cyc, 1);
  endtask

  task automatic wrr_run(input logic [7:0] q, input int cnt);
    int order[$];
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.wrr_enable = 1'b1; bus.queue_nonempty = q; bus.ready = 1'b1;
`ifdef PORT_RD_WRR_EN
    while (order.size() < cnt)
      for (int p = 7; p >= 0; p--)
        if (q[p]) for (int w = 0; w <= p; w++) order.push_back(p);
`else
    for (int i = 0; i < cnt; i++) order.push_back(int'(hi(q)));
`endif
    for (int i = 0; i < cnt; i++) run_pkt(3'(order[i]), 5'(i), 11'($urandom), 9'd0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1;
    bus.ready = 1'b0; bus.wrr_enable = 1'b0; bus.queue_nonempty = '0; bus.pop_ack = 1'b0;
    bus.pkt_sram = '0; bus.pkt_head = '0; bus.pkt_length = '0; bus.sram_rd_gnt = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ctl", {bus.pop_req, bus.pop_prior, bus.sram_rd_en, bus.sram_rd_sram, bus.sram_rd_addr}, 0);
    chk("rst_stream", {bus.rd_sop, bus.rd_eop, bus.rd_vld, bus.rd_data}, 0);
    rst = 1'b0;
    bus.queue_nonempty = 8'h24; bus.ready = 1'b1;
    run_pkt(3'd5, 5'd3, 11'd100, 9'd3, 0, 0, 0, 0, 0);
    bus.queue_nonempty = 8'h81;
    run_pkt(3'd7, 5'd9, 11'd2046, 9'd3, 1, 0, 0, 0, 0);
    bus.queue_nonempty = 8'h0f;
    run_pkt(3'd3, 5'd1, 11'd500, 9'd5, 0, 1, 3, 0, 1);
    bus.pop_ack = 1'b1; bus.pkt_length = 9'd7;
    @(negedge clk);
    bus.pop_ack = 1'b0;
    @(negedge clk);
    chk("stray_ack", {bus.rd_sop, bus.sram_rd_en, bus.pop_req}, 0);
    bus.queue_nonempty = 8'h02; bus.ready = 1'b1;
    for (int t = 0; t < 10 && !bus.pop_req; t++) @(negedge clk);
    chk("rst_pop", {bus.pop_req, bus.pop_prior}, {1'b1, 3'd1});
    bus.pop_ack = 1'b1; bus.pkt_sram = 5'd4; bus.pkt_head = 11'd10; bus.pkt_length = 9'd20;
    @(negedge clk);
    bus.pop_ack = 1'b0; bus.ready = 1'b0; bus.sram_rd_gnt = 1'b1;
    repeat (3) @(negedge clk);
    chk("mid_issue", bus.sram_rd_en, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_ctl", {bus.pop_req, bus.pop_prior, bus.sram_rd_en, bus.sram_rd_sram, bus.sram_rd_addr}, 0);
    chk("rst_mid_stream", {bus.rd_sop, bus.rd_eop, bus.rd_vld, bus.rd_data}, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rst_quiet", {bus.pop_req, bus.rd_vld, bus.rd_eop, bus.sram_rd_en}, 0);
    end
    bus.sram_rd_gnt = 1'b0;
    for (int p = 0; p < 15; p++) begin
      logic [7:0] q;
      q = 8'($urandom_range(1, 255));
      bus.queue_nonempty = q; bus.ready = 1'b1;
      run_pkt(hi(q), 5'($urandom), 11'($urandom), 9'($urandom_range(0, 12)),
              $urandom_range(0, 2), 0, 0, 1, 1'($urandom));
    end
    wrr_run(8'hff, 40);
    wrr_run(8'h7f, 13);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
